// File: rtl/fp32_mul_seq.sv
// Sequential fp32 multiplier: 24-cycle shift-add mantissa product, then normalise,
// round-to-nearest-even and pack, with a one-cycle done pulse.
module fp32_mul_seq (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] result,
  output logic        done,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, MUL, NORM, PACK} state_t;

  state_t             state;
  logic [4:0]         cnt;

  logic               sign_p0;
  logic signed [9:0]  exp_p0;
  logic [47:0]        mcand_p0;
  logic [47:0]        prod_p0;
  logic [23:0]        mplier_p0;
  logic               nan_p0;
  logic               inf_p0;
  logic               zero_p0;

  logic [22:0]        mant_p1;
  logic               guard_p1;
  logic               sticky_p1;
  logic signed [9:0]  exp_p1;

  logic [7:0]         ea;
  logic [7:0]         eb;
  logic               a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
  logic signed [9:0]  exp_sum;
  logic [32:0]        rnd_p1;
  logic signed [9:0]  exp_rnd;

  function automatic logic [32:0] round_rne(input logic [22:0] mant,
                                            input logic        guard,
                                            input logic        sticky,
                                            input logic signed [9:0] e);
    logic [23:0]       sum;
    logic signed [9:0] e_out;
    sum   = {1'b0, mant} + {23'd0, guard & (sticky | mant[0])};
    e_out = e;
    // A carry out of the fraction leaves sum[22:0] at zero, i.e. mantissa 1.0 at E+1.
    if (sum[23]) e_out = e + 10'sd1;
    return {e_out, sum[22:0]};
  endfunction

  function automatic logic [31:0] saturate(input logic              sgn,
                                           input logic signed [9:0] e,
                                           input logic [22:0]       mant);
    if (e >= 10'sd255)     return {sgn, 8'hFF, 23'd0};
    else if (e <= 10'sd0)  return {sgn, 31'd0};
    else                   return {sgn, e[7:0], mant};
  endfunction

  assign ea      = a[30:23];
  assign eb      = b[30:23];
  assign a_zero  = (ea == 8'h00);
  assign b_zero  = (eb == 8'h00);
  assign a_inf   = (ea == 8'hFF) && (a[22:0] == 23'd0);
  assign b_inf   = (eb == 8'hFF) && (b[22:0] == 23'd0);
  assign a_nan   = (ea == 8'hFF) && (a[22:0] != 23'd0);
  assign b_nan   = (eb == 8'hFF) && (b[22:0] != 23'd0);
  assign exp_sum = $signed({2'b00, ea}) + $signed({2'b00, eb}) - 10'sd127;

  assign rnd_p1  = round_rne(mant_p1, guard_p1, sticky_p1, exp_p1);
  assign exp_rnd = rnd_p1[32:23];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= 5'd0;
      result    <= 32'd0;
      done      <= 1'b0;
      busy      <= 1'b0;
      sign_p0   <= 1'b0;
      exp_p0    <= 10'sd0;
      mcand_p0  <= 48'd0;
      prod_p0   <= 48'd0;
      mplier_p0 <= 24'd0;
      nan_p0    <= 1'b0;
      inf_p0    <= 1'b0;
      zero_p0   <= 1'b0;
      mant_p1   <= 23'd0;
      guard_p1  <= 1'b0;
      sticky_p1 <= 1'b0;
      exp_p1    <= 10'sd0;
    end else begin
      case (state)
        // Capture and classify operands
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            sign_p0   <= a[31] ^ b[31];
            exp_p0    <= exp_sum;
            mcand_p0  <= {24'd0, 1'b1, a[22:0]};
            mplier_p0 <= {1'b1, b[22:0]};
            prod_p0   <= 48'd0;
            nan_p0    <= a_nan | b_nan | (a_inf & b_zero) | (b_inf & a_zero);
            inf_p0    <= a_inf | b_inf;
            zero_p0   <= a_zero | b_zero;
            cnt       <= 5'd0;
            busy      <= 1'b1;
            state     <= MUL;
          end else begin
            busy <= 1'b0;
          end
        end
        // Shift-add: one multiplier bit per cycle, LSB first
        MUL: begin
          if (mplier_p0[0]) prod_p0 <= prod_p0 + mcand_p0;
          mcand_p0  <= mcand_p0 << 1;
          mplier_p0 <= mplier_p0 >> 1;
          cnt       <= cnt + 5'd1;
          if (cnt == 5'd23) state <= NORM;
        end
        // Normalise product in [1,4) to [1,2) and extract guard/sticky
        NORM: begin
          if (prod_p0[47]) begin
            mant_p1   <= prod_p0[46:24];
            guard_p1  <= prod_p0[23];
            sticky_p1 <= |prod_p0[22:0];
            exp_p1    <= exp_p0 + 10'sd1;
          end else begin
            mant_p1   <= prod_p0[45:23];
            guard_p1  <= prod_p0[22];
            sticky_p1 <= |prod_p0[21:0];
            exp_p1    <= exp_p0;
          end
          state <= PACK;
        end
        // Round, range-limit and apply special-case overrides
        PACK: begin
          if (nan_p0)       result <= 32'h7FC00000;
          else if (inf_p0)  result <= {sign_p0, 8'hFF, 23'd0};
          else if (zero_p0) result <= {sign_p0, 31'd0};
          else              result <= saturate(sign_p0, exp_rnd, rnd_p1[22:0]);
          done  <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fp32_mul_seq.sv
// Directed testbench for fp32_mul_seq: products, rounding, specials, handshake and reset.
module tb_fp32_mul_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [31:0] a;
  logic [31:0] b;
  logic [31:0] result;
  logic        done;
  logic        busy;

  int n_vec = 0;
  int n_err = 0;

  fp32_mul_seq dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .a      (a),
    .b      (b),
    .result (result),
    .done   (done),
    .busy   (busy)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic launch(input logic [31:0] xa, input logic [31:0] xb);
    a     = xa;
    b     = xb;
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  // Steps from the start edge until done is seen; lat = -1 if it never comes.
  task automatic wait_done(output int lat, output int bcnt);
    lat  = -1;
    bcnt = 0;
    for (int n = 0; n <= 40; n++) begin
      if (done) begin
        lat = n;
        break;
      end
      if (busy) bcnt++;
      step();
    end
  endtask

  task automatic run_op(input string tag, input logic [31:0] xa, input logic [31:0] xb,
                        input logic [31:0] exp);
    int lat;
    int bc;
    launch(xa, xb);
    wait_done(lat, bc);
    check({tag, "_lat"}, lat, 26);
    check({tag, "_res"}, result, exp);
  endtask

  initial begin
    int lat;
    int bc;
    int ndone;
    int last_n;
    int prev_done;
    int consec;

    rst_n = 1'b0;
    start = 1'b0;
    a     = 32'd0;
    b     = 32'd0;
    step();
    step();
    check("rst_result", result, 32'h0);
    check("rst_done", done, 1'b0);
    check("rst_busy", busy, 1'b0);
    rst_n = 1'b1;
    step();

    // Normal product with full timing checks
    launch(32'hC0700000, 32'h3FC00000);
    check("norm_busy_after_start", busy, 1'b1);
    wait_done(lat, bc);
    check("norm_lat", lat, 26);
    check("norm_busy_cycles", bc, 26);
    check("norm_res", result, 32'hC0B40000);
    check("norm_busy_in_done", busy, 1'b1);
    step();
    check("norm_done_drop", done, 1'b0);
    check("norm_busy_drop", busy, 1'b0);
    a = 32'h12345678;
    b = 32'h9ABCDEF0;
    step();
    step();
    check("norm_res_hold", result, 32'hC0B40000);

    run_op("mix1", 32'h42480000, 32'hC1C80000, 32'hC49C4000);
    run_op("mix2", 32'h40000000, 32'h40400000, 32'h40C00000);
    run_op("rnd", 32'h3F800001, 32'h3F800001, 32'h3F800002);
    run_op("infx0", 32'h7F800000, 32'h00000000, 32'h7FC00000);
    run_op("ovf", 32'h7F000000, 32'h7F000000, 32'h7F800000);
    run_op("unf", 32'h00800000, 32'h00800000, 32'h00000000);
    run_op("denorm", 32'h00000001, 32'h3F800000, 32'h00000000);
    run_op("nan", 32'h7FC00001, 32'h3F800000, 32'h7FC00000);
    run_op("ninfx2", 32'hFF800000, 32'h40000000, 32'hFF800000);
    run_op("negzero", 32'h80000000, 32'h40400000, 32'h80000000);
    step();

    // Start re-pulsed mid-MUL with different operands must be ignored
    launch(32'h40000000, 32'h40400000);
    for (int i = 0; i < 5; i++) step();
    a     = 32'h7F800000;
    b     = 32'h00000000;
    start = 1'b1;
    step();
    start = 1'b0;
    wait_done(lat, bc);
    check("repulse_lat", lat + 6, 26);
    check("repulse_res", result, 32'h40C00000);
    step();
    check("repulse_idle_busy", busy, 1'b0);
    step();

    // Start held high: one done every 27 cycles, never two in a row
    a         = 32'h42480000;
    b         = 32'hC1C80000;
    start     = 1'b1;
    step();
    ndone     = 0;
    last_n    = -1;
    prev_done = 0;
    consec    = 0;
    for (int n = 1; n <= 80; n++) begin
      step();
      if (done) begin
        if (prev_done != 0) consec++;
        ndone++;
        last_n = n;
      end
      prev_done = done ? 1 : 0;
    end
    start = 1'b0;
    check("b2b_count", ndone, 3);
    check("b2b_last", last_n, 80);
    check("b2b_consec", consec, 0);
    check("b2b_res", result, 32'hC49C4000);
    step();
    check("b2b_end_done", done, 1'b0);
    check("b2b_end_busy", busy, 1'b0);

    // Reset mid-operation aborts without a done
    launch(32'h40000000, 32'h40400000);
    for (int i = 0; i < 10; i++) step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    check("midrst_busy", busy, 1'b0);
    check("midrst_done", done, 1'b0);
    check("midrst_result", result, 32'h0);
    ndone = 0;
    for (int i = 0; i < 30; i++) begin
      step();
      if (done) ndone++;
    end
    check("midrst_no_stale_done", ndone, 0);
    run_op("post_rst", 32'hC0700000, 32'h3FC00000, 32'hC0B40000);
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/fp32_mul_seq.md
# fp32_mul_seq

Sequential IEEE-754 single-precision multiplier: the companion to the team's fp32 divider `div` in the ALU datapath. It is the inverse operation, so a divide result can be checked by multiplying it back. The block accepts two operands on a start pulse and computes the 24×24 mantissa product with an iterative shift-add over 24 cycles. It then normalises, rounds to nearest-even and presents a packed fp32 result with a one-cycle done pulse.

## Interface
- No parameters; format fixed at fp32 (1/8/23, bias 127).
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous active-low reset
- start  input  1  request; sampled only in IDLE
- a  input  32  operand A, captured on accepted start
- b  input  32  operand B, captured on accepted start
- result  output  32  product; held stable from done until the next done
- done  output  1  one-cycle pulse; result valid in that cycle
- busy  output  1  high from the cycle after accepted start through the done cycle

## Operation
- Reset: with rst_n=0 at a clk edge, go to IDLE, result=0x00000000, done=0, busy=0, internal accumulators cleared. Reset aborts any operation in flight; no done is produced for it.
- States:
  - IDLE: start=1 captures a, b, goes to MUL, sets busy.
  - MUL: 24 cycles, bit counter 0..23.
  - NORM: 1 cycle.
  - PACK: 1 cycle; result registered, done=1 in the following cycle.
  - From PACK to IDLE: busy drops together with done.
- Unpack:
  - sign = a[31]^b[31].
  - Exponent fields 0 mark zero, including denormals (flushed to signed zero).
  - Exponent field 255 with a zero fraction is inf; with a non-zero fraction it is NaN.
  - Mantissa = {1, frac} for normal operands.
- MUL: 48-bit product P accumulated by shift-add. Each cycle adds the shifted multiplicand when the current multiplier bit is 1.
- Exponent: 10-bit signed, E = ea + eb − 127.
- NORM:
  - If P[47]=1: mant=P[46:24], guard=P[23], sticky=|P[22:0], E=E+1.
  - Else: mant=P[45:23], guard=P[22], sticky=|P[21:0].
- Round to nearest-even: increment when guard & (sticky | mant[0]). If rounding overflows the mantissa, mant=0 and E=E+1.
- Range:
  - E ≥ 255 gives ±inf (exp 0xFF, frac 0).
  - E ≤ 0 gives ±0 (no denormal outputs).
- Specials, which override arithmetic but keep the same latency:
  - Any NaN operand, or inf×0, gives canonical 0x7FC00000.
  - inf×finite-nonzero gives ±inf.
  - Zero×finite gives signed zero.
- start while busy=1 is ignored, and the operands are not recaptured.
- a and b may change freely after the accepting edge.

## Timing
- Fixed latency: start sampled high in IDLE at edge k leads to done=1 and a valid result in the cycle after edge k+26 (24 MUL + NORM + PACK).
- Back-to-back: start held high continuously is accepted again in the IDLE cycle immediately after done. The throughput is then one result per 27 cycles.
- done is never high for two consecutive cycles. busy=0 and done=0 in every IDLE cycle except the done cycle itself.
- result changes only at the edge that raises done, or on reset.

## Test plan
- Normal product: a=0xC0700000 (−3.75), b=0x3FC00000 (1.5) → result=0xC0B40000 (−5.625); done exactly 26 cycles after the start edge; busy high 26 cycles.
- Mixed sign and exponent carry:
  - 0x42480000 × 0xC1C80000 → 0xC49C4000 (−1250).
  - 0x40000000 × 0x40400000 → 0x40C00000.
- Rounding: 0x3F800001 × 0x3F800001 → 0x3F800002 (guard 0, sticky 1, round down).
- Specials and range:
  - inf×0 → 0x7FC00000.
  - 0x7F000000 × 0x7F000000 → 0x7F800000.
  - 0x00800000 × 0x00800000 → 0x00000000.
  - Denormal 0x00000001 × 0x3F800000 → 0x00000000.
- Handshake: start re-pulsed mid-MUL with different operands is ignored, and the first product completes unchanged. Start held high gives exactly one done per 27 cycles.
- Reset mid-operation: rst_n=0 for one edge during MUL → next cycle busy=0, done=0, result=0. A new start then completes normally with no stale done.
